branch_commit_queue: RTL
========================

// Module: branch_commit_queue
// PURPOSE
//  In-order FIFO of in-flight conditional branches between fetch/issue and branch execution.
//  Captures each issued branch's PHT index, 2-bit prediction and recovery address.
//  On resolution, checks taken/not-taken against the prediction.
//  Drives the fetch stage's predictor-update and misprediction-recovery inputs:
//  commit_b, pattern_end, prediction_end, failure, addr_on_failure.
// PARAMETERS
//  DEPTH      8               entries; power of two, >=2
//  PTR_WIDTH  $clog2(DEPTH)   read/write pointer width (derived, do not override)
//  (PATTERN_WIDTH, INST_MEM_WIDTH are global constants from common.vh)
// PORTS
//  clk              in   1               single clock, rising edge
//  reset            in   1               synchronous, active-high; empties queue
//  push             in   1               issue of a conditional branch this cycle
//  push_pattern     in   PATTERN_WIDTH   PHT index used at fetch (pattern_begin)
//  push_prediction  in   2               PHT counter read at fetch (prediction_begin)
//  push_alt_addr    in   INST_MEM_WIDTH  address to refetch if prediction wrong
//  full             out  1               no free entry; issue must stall
//  empty            out  1               no entries
//  count            out  PTR_WIDTH+1     occupancy 0..DEPTH
//  resolve          in   1               oldest branch resolved this cycle
//  resolve_taken    in   1               actual direction of oldest branch
//  commit_b         out  1               one-cycle pulse: predictor update strobe
//  pattern_end      out  PATTERN_WIDTH   PHT index of committed branch
//  prediction_end   out  2               original prediction of committed branch
//  failure          out  1               one-cycle pulse with commit_b: mispredicted
//  addr_on_failure  out  INST_MEM_WIDTH  recovery fetch address (valid with failure)
// BEHAVIOUR
//  - Reset: rd_ptr=wr_ptr=0, count=0, empty=1, full=0.
//    commit_b=0, failure=0, pattern_end=0, prediction_end=0, addr_on_failure=0.
//    Reset beats push/resolve in the same cycle.
//  - Push: accepted when push && !full. Writes {pattern, prediction, alt_addr} at wr_ptr.
//    wr_ptr increments mod DEPTH.
//  - Push while full: ignored, no state change. Upstream guarantees stall.
//  - Resolve: accepted when resolve && !empty. Reads entry at rd_ptr; rd_ptr increments mod DEPTH.
//  - Resolve while empty: ignored, no pulse. No bypass: a branch pushed this cycle is not resolvable this cycle.
//  - Latency 1: resolve accepted at edge N -> commit_b=1 during cycle N+1, with pattern_end/prediction_end of that entry.
//    failure = resolve_taken ^ prediction[1].
//    addr_on_failure = entry alt_addr.
//    commit_b/failure are 0 in every other cycle.
//  - Outputs are registered; pattern_end/prediction_end/addr_on_failure hold their value until the next commit.
//  - Misprediction flush: when a resolve is accepted and mispredicts, all younger entries are wrong-path.
//    At that same edge: count=0 and rd_ptr=wr_ptr.
//    A simultaneous push is dropped.
//    The top level also derives the fetch-side reset from failure.
//  - Push+resolve in the same cycle, correct prediction: count unchanged, both pointers advance.
//  - count/full/empty are registered, consistent with the pointers after the edge.
//  - Pointer wrap: DEPTH is a power of two, so wrap is natural overflow.
//    full/empty are derived from count, never from pointer equality.
//  - Storage: distributed RAM, write-synchronous, read-asynchronous at rd_ptr.
// STRUCTURE
//  - common.vh gains typedef bq_entry_t {logic[PATTERN_WIDTH-1:0] pattern; logic[1:0] prediction;
//    logic[INST_MEM_WIDTH-1:0] alt_addr}.
//    It also gains localparam BQ_DEPTH=8, shared with the issue stage for stall logic.
//  - One sub-module: bq_storage, a DEPTH x bq_entry_t distributed RAM with one write port and one async read port.
//  - Pointer/count control and output registers live in branch_commit_queue.
// TESTING
//  1 Reset then idle: all outputs 0, empty=1, count=0. Resolve on empty -> no commit_b.
//  2 Push {pattern=0x2A, pred=2'b11, alt=0x105}; next cycle resolve taken=1 ->
//    one cycle later commit_b=1, failure=0, pattern_end=0x2A, prediction_end=2'b11; count=0.
//  3 Push pred=2'b01, alt=0x200; resolve taken=1 ->
//    failure=1, addr_on_failure=0x200, prediction_end=2'b01.
//  4 Push 8 entries -> full=1, count=8. 9th push ignored.
//    Then 8 correct resolves commit patterns in push order; empty=1.
//  5 Steady state, push+resolve every cycle for 20 cycles (pointer wrap) ->
//    count constant, pattern_end sequence matches push order.
//  6 Queue holds 3 entries; oldest mispredicts while push=1 ->
//    failure=1 next cycle, count=0, pushed entry absent.
//    Reset asserted mid-run with 5 entries -> count=0 and no commit_b next cycle.

Source files
------------

// File: rtl/branch_commit_queue_pkg.sv
// ============================================================================
// Module   : branch_commit_queue_pkg
// Brief    : Shared widths, queue depth and entry type for the branch queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package branch_commit_queue_pkg;

    localparam int PATTERN_WIDTH  = 8;
    localparam int INST_MEM_WIDTH = 12;
    localparam int BQ_DEPTH       = 8;

    typedef struct packed {
        logic [PATTERN_WIDTH-1:0]  pattern;
        logic [1:0]                prediction;
        logic [INST_MEM_WIDTH-1:0] alt_addr;
    } bq_entry_t;

endpackage

`default_nettype wire

// File: rtl/branch_commit_queue_storage.sv
// ============================================================================
// Module   : bq_storage
// Brief    : DEPTH x bq_entry_t distributed RAM, sync write, async read.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bq_storage
    import branch_commit_queue_pkg::*;
#(
    parameter int DEPTH     = BQ_DEPTH,
    parameter int PTR_WIDTH = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [PTR_WIDTH-1:0] wr_addr,
    input  bq_entry_t            wr_data,
    input  logic [PTR_WIDTH-1:0] rd_addr,
    output bq_entry_t            rd_data
);

    bq_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/branch_commit_queue.sv
// ============================================================================
// Module   : branch_commit_queue
// Brief    : In-order queue of in-flight branches; commits predictor updates
//            and flags mispredictions with the recovery address.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_commit_queue
    import branch_commit_queue_pkg::*;
#(
    parameter int DEPTH     = BQ_DEPTH,
    parameter int PTR_WIDTH = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic [PATTERN_WIDTH-1:0]  push_pattern,
    input  logic [1:0]                push_prediction,
    input  logic [INST_MEM_WIDTH-1:0] push_alt_addr,
    output logic                      full,
    output logic                      empty,
    output logic [PTR_WIDTH:0]        count,
    input  logic                      resolve,
    input  logic                      resolve_taken,
    output logic                      commit_b,
    output logic [PATTERN_WIDTH-1:0]  pattern_end,
    output logic [1:0]                prediction_end,
    output logic                      failure,
    output logic [INST_MEM_WIDTH-1:0] addr_on_failure
);

    localparam logic [PTR_WIDTH:0] FULL_COUNT = (PTR_WIDTH + 1)'(DEPTH);

    logic [PTR_WIDTH-1:0] rd_ptr;
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH:0]   next_count;
    logic                 push_ok;
    logic                 resolve_ok;
    logic                 mispredict;
    bq_entry_t            wr_entry;
    bq_entry_t            rd_entry;

    assign push_ok    = push && !full;
    assign resolve_ok = resolve && !empty;
    assign mispredict = resolve_ok && (resolve_taken ^ rd_entry.prediction[1]);

    assign wr_entry.pattern    = push_pattern;
    assign wr_entry.prediction = push_prediction;
    assign wr_entry.alt_addr   = push_alt_addr;

    // A push coinciding with a mispredict is wrong-path and never written.
    bq_storage #(
        .DEPTH     (DEPTH),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_storage (
        .clk     (clk),
        .we      (push_ok && !mispredict),
        .wr_addr (wr_ptr),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr),
        .rd_data (rd_entry)
    );

    always_comb begin
        next_count = count;
        if (mispredict) begin
            next_count = '0;
        end else if (push_ok && !resolve_ok) begin
            next_count = count + 1'b1;
        end else if (resolve_ok && !push_ok) begin
            next_count = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr          <= '0;
            wr_ptr          <= '0;
            count           <= '0;
            full            <= 1'b0;
            empty           <= 1'b1;
            commit_b        <= 1'b0;
            failure         <= 1'b0;
            pattern_end     <= '0;
            prediction_end  <= '0;
            addr_on_failure <= '0;
        end else begin
            count    <= next_count;
            full     <= (next_count == FULL_COUNT);
            empty    <= (next_count == '0);
            commit_b <= resolve_ok;
            failure  <= mispredict;

            if (mispredict) begin
                rd_ptr <= wr_ptr;
            end else begin
                if (push_ok) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (resolve_ok) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end

            if (resolve_ok) begin
                pattern_end     <= rd_entry.pattern;
                prediction_end  <= rd_entry.prediction;
                addr_on_failure <= rd_entry.alt_addr;
            end
        end
    end

endmodule

`default_nettype wire
